// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS multiply/divide unit.
// Operation codes, FSM states and default operand width.
package mips_cpu_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_core.sv
// Unsigned shift-add multiplier / restoring divider, one bit per step.
// MIPS_MULDIV_FAST_MULT_EN: products computed in one shot on load.
module mips_cpu_muldiv_core
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] raw,
  output logic               last
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             div_q, div_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;

`ifdef MIPS_MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, opa} * {{WIDTH{1'b0}}, opb};
`endif

  assign raw  = {acc_hi_q, acc_lo_q};
  assign last = (cnt_q == '0);

  // Load operands or advance one multiply/divide iteration.
  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    dsr_d    = dsr_q;
    div_d    = div_q;
    mul_sum  = {1'b0, acc_hi_q}
             + (acc_lo_q[0] ? {1'b0, dsr_q} : '0);
    div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, dsr_q};
    if (load) begin
      cnt_d    = CW'(WIDTH - 1);
      acc_hi_d = '0;
      acc_lo_d = opa;
      dsr_d    = opb;
      div_d    = is_div;
`ifdef MIPS_MULDIV_FAST_MULT_EN
      if (!is_div) begin
        {acc_hi_d, acc_lo_d} = fast_prod;
      end
`endif
    end else if (step) begin
      cnt_d = cnt_q - 1'b1;
      if (div_q) begin
        if (!div_diff[WIDTH]) begin
          acc_hi_d = div_diff[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi_d = div_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
    end
  end

  // Datapath registers, frozen while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      dsr_q    <= '0;
      div_q    <= 1'b0;
    end else if (clk_enable) begin
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      dsr_q    <= dsr_d;
      div_q    <= div_d;
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO register pair with iterative multiply/divide.
// MIPS_MULDIV_FAST_MULT_EN: single-cycle MULT/MULTU.
module mips_cpu_muldiv
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  muldiv_state_t    state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             divz_q, divz_d;

  logic               is_signed, is_mul, is_dv;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   opa_abs, opb_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  logic               core_load, core_step, core_last;
  logic [2*WIDTH-1:0] core_raw;

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Operand decode: magnitudes plus sign flags.
  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_dv     = (op == OP_DIV) || (op == OP_DIVU);
    sgn_a     = is_signed & a[WIDTH-1];
    sgn_b     = is_signed & b[WIDTH-1];
    opa_abs   = sgn_a ? -a : a;
    opb_abs   = sgn_b ? -b : b;
  end

  // Sign fix-up of the raw unsigned result.
  always_comb begin
    prod_fix = neg_q ? -core_raw : core_raw;
    quo_fix  = neg_q ? -core_raw[WIDTH-1:0]
                     : core_raw[WIDTH-1:0];
    rem_fix  = rneg_q ? -core_raw[2*WIDTH-1:WIDTH]
                      : core_raw[2*WIDTH-1:WIDTH];
  end

  // Next-state and HI/LO update logic.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dvd_d     = dvd_q;
    div_d     = div_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    divz_d    = divz_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (1'b1)
            (op == OP_MTHI): begin
              hi_d   = a;
              done_d = 1'b1;
            end
            (op == OP_MTLO): begin
              lo_d   = a;
              done_d = 1'b1;
            end
            (is_mul || is_dv): begin
              core_load = 1'b1;
              div_d     = is_dv;
              neg_d     = sgn_a ^ sgn_b;
              rneg_d    = sgn_a;
              divz_d    = is_dv && (b == '0);
              dvd_d     = a;
              state_d   = S_CALC;
`ifdef MIPS_MULDIV_FAST_MULT_EN
              if (is_mul) begin
                state_d = S_FIX;
              end
`endif
            end
            default: ;
          endcase
        end
      end
      S_CALC: begin
        core_step = 1'b1;
        if (core_last) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (!div_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (divz_q) begin
          lo_d = '1;
          hi_d = dvd_q;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and architectural state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvd_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else if (clk_enable) begin
      state_q <= state_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
    end
  end

  mips_cpu_muldiv_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .load      (core_load),
    .step      (core_step),
    .is_div    (is_dv),
    .opa       (opa_abs),
    .opb       (opb_abs),
    .raw       (core_raw),
    .last      (core_last)
  );

endmodule
